// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared definitions for the interrupt request latch front-end.
//               Holds default sizing constants and the grant FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    localparam int N_DEF     = 8;
    localparam int IDX_W_DEF = 3;

    // Grant FSM states; code 2'd3 is unused and decodes to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        GAP   = 2'd2
    } irq_state_t;

endpackage
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : irq_sync_edge
// Description : SYNC_STAGES-deep synchroniser for one asynchronous request
//               line, followed by a rising-edge detector.
// Ports       : clk    - clock
//               rst    - asynchronous active-high reset
//               i_irq  - raw request line, asynchronous to clk
//               o_rise - one-cycle pulse on a synchronised 0->1 transition
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_irq,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // r_prev resets to 0 so a line held high through reset yields one edge
    // once the synchroniser fills after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/irq_req_latch.sv
`default_nettype none
// ============================================================================
// Module      : irq_req_latch
// Description : Front-end for the N-input priority encoder. Synchronises
//               request lines, latches rising edges into sticky pending bits,
//               applies a writable mask and sequences the encoder enable
//               with a one-cycle gap between grants.
// Ports       : clk, rst            - clock, asynchronous active-high reset
//               irq_in[N]           - raw request lines (async)
//               mask_wr, mask_din   - mask register write (1 = line enabled)
//               ack_valid, ack_idx  - consumer acknowledge of serviced index
//               req_out[N]          - pending & mask, encoder input a
//               req_en              - encoder enable, high only in ARMED
//               pend_out[N]         - raw pending register
//               ovf_out[N]          - sticky overflow flags
// Config      : IRQ_LATCH_OVF_EN - when defined, ovf flops are built;
//               otherwise ovf_out is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_req_latch
    import irq_pkg::*;
#(
    parameter int N           = N_DEF,
    parameter int IDX_W       = IDX_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     irq_in,
    input  logic             mask_wr,
    input  logic [N-1:0]     mask_din,
    input  logic             ack_valid,
    input  logic [IDX_W-1:0] ack_idx,
    output logic [N-1:0]     req_out,
    output logic             req_en,
    output logic [N-1:0]     pend_out,
    output logic [N-1:0]     ovf_out
);

    localparam logic [IDX_W:0] c_n = (IDX_W+1)'(N);

    logic [N-1:0] w_rise;
    logic [N-1:0] w_clr;
    logic         w_ack_ok;
    logic         w_any;

    logic [N-1:0] r_mask;
    logic [N-1:0] r_pend;
    irq_state_t   r_state;
    logic         r_req_en;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_line
            irq_sync_edge #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync_edge (
                .clk    (clk),
                .rst    (rst),
                .i_irq  (irq_in[gi]),
                .o_rise (w_rise[gi])
            );
        end
    endgenerate

    // Acks are honoured only while the encoder is enabled and in range.
    assign w_ack_ok = ack_valid && (r_state == ARMED) && ({1'b0, ack_idx} < c_n);
    assign w_any    = |(r_pend & r_mask);

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < N; i++) begin
            if (w_ack_ok && (ack_idx == IDX_W'(i))) begin
                w_clr[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= '1;
        end else if (mask_wr) begin
            r_mask <= mask_din;
        end
    end

    // OR-ing rise after the clear lets a same-cycle new edge win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_rise;
        end
    end

`ifdef IRQ_LATCH_OVF_EN
    logic [N-1:0] r_ovf;

    // A re-edge on a bit being cleared this cycle is not an overflow: the
    // pending bit simply carries the new edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= (r_ovf & ~w_clr) | (w_rise & r_pend & ~w_clr);
        end
    end

    assign ovf_out = r_ovf;
`else
    assign ovf_out = '0;
`endif

    // req_en is registered alongside the state so it is high exactly in ARMED.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_req_en <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state  <= ARMED;
                        r_req_en <= 1'b1;
                    end
                end
                ARMED: begin
                    if (w_ack_ok) begin
                        r_state  <= GAP;
                        r_req_en <= 1'b0;
                    end else if (!w_any) begin
                        r_state  <= IDLE;
                        r_req_en <= 1'b0;
                    end
                end
                GAP: begin
                    if (w_any) begin
                        r_state  <= ARMED;
                        r_req_en <= 1'b1;
                    end else begin
                        r_state  <= IDLE;
                        r_req_en <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_req_en <= 1'b0;
                end
            endcase
        end
    end

    assign req_out  = r_pend & r_mask;
    assign req_en   = r_req_en;
    assign pend_out = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_irq_req_latch.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_req_latch
// Description : Self-checking bench for irq_req_latch. Cycle-by-cycle vector
//               table for the main flows plus hand sequences for collision,
//               asynchronous reset and overflow corners.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_req_latch;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq_in;
    logic       mask_wr;
    logic [7:0] mask_din;
    logic       ack_valid;
    logic [2:0] ack_idx;
    logic [7:0] req_out;
    logic       req_en;
    logic [7:0] pend_out;
    logic [7:0] ovf_out;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef IRQ_LATCH_OVF_EN
    localparam logic [7:0] c_ovf4 = 8'h10;
`else
    localparam logic [7:0] c_ovf4 = 8'h00;
`endif

    irq_req_latch u_dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .mask_wr   (mask_wr),
        .mask_din  (mask_din),
        .ack_valid (ack_valid),
        .ack_idx   (ack_idx),
        .req_out   (req_out),
        .req_en    (req_en),
        .pend_out  (pend_out),
        .ovf_out   (ovf_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] irq;
        logic       mwr;
        logic [7:0] mdin;
        logic       av;
        logic [2:0] aidx;
        logic [7:0] epend;
        logic [7:0] ereq;
        logic       een;
        logic [7:0] eovf;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic [7:0] irq, logic mwr, logic [7:0] mdin,
                                logic av, logic [2:0] aidx, logic [7:0] epend,
                                logic [7:0] ereq, logic een, logic [7:0] eovf);
        vec_t v;
        v.irq = irq; v.mwr = mwr; v.mdin = mdin; v.av = av; v.aidx = aidx;
        v.epend = epend; v.ereq = ereq; v.een = een; v.eovf = eovf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [7:0] ep, input logic [7:0] er,
                           input logic ee, input logic [7:0] eo);
        chk({nm, ".pend"}, pend_out, ep);
        chk({nm, ".req"},  req_out,  er);
        chk({nm, ".en"},   {7'd0, req_en}, {7'd0, ee});
        chk({nm, ".ovf"},  ovf_out,  eo);
    endtask

    // Apply inputs, take one rising edge, check outputs 1 time unit later.
    task automatic step(input string nm, input logic [7:0] irq, input logic mwr,
                        input logic [7:0] mdin, input logic av, input logic [2:0] aidx,
                        input logic [7:0] ep, input logic [7:0] er, input logic ee,
                        input logic [7:0] eo);
        irq_in = irq; mask_wr = mwr; mask_din = mdin; ack_valid = av; ack_idx = aidx;
        @(posedge clk);
        #1;
        chk_all(nm, ep, er, ee, eo);
    endtask

    initial begin
        // T1 reset
        rst = 1'b1; irq_in = 8'h00; mask_wr = 1'b0; mask_din = 8'h00;
        ack_valid = 1'b0; ack_idx = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("t1_reset", 8'h00, 8'h00, 1'b0, 8'h00);
        rst = 1'b0;

        // T2 single edge on bit 5
        vq.push_back(mk(8'h20, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h20, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h20, 0, 8'h00, 0, 3'd0, 8'h20, 8'h20, 0, 8'h00));
        vq.push_back(mk(8'h20, 0, 8'h00, 0, 3'd0, 8'h20, 8'h20, 1, 8'h00));
        vq.push_back(mk(8'h20, 0, 8'h00, 1, 3'd5, 8'h00, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h20, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00));
        // T3 edges on bits 7 and 1, GAP then re-arm
        vq.push_back(mk(8'h82, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h82, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h82, 0, 8'h00, 0, 3'd0, 8'h82, 8'h82, 0, 8'h00));
        vq.push_back(mk(8'h82, 0, 8'h00, 0, 3'd0, 8'h82, 8'h82, 1, 8'h00));
        vq.push_back(mk(8'h82, 0, 8'h00, 1, 3'd7, 8'h02, 8'h02, 0, 8'h00));
        vq.push_back(mk(8'h82, 0, 8'h00, 0, 3'd0, 8'h02, 8'h02, 1, 8'h00));
        vq.push_back(mk(8'h82, 0, 8'h00, 1, 3'd1, 8'h00, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h82, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00));
        // T4 masked line latches but stays hidden; ack in IDLE ignored
        vq.push_back(mk(8'h00, 1, 8'hFB, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h04, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h04, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h04, 0, 8'h00, 0, 3'd0, 8'h04, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h04, 0, 8'h00, 1, 3'd2, 8'h04, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h04, 1, 8'hFF, 0, 3'd0, 8'h04, 8'h04, 0, 8'h00));
        vq.push_back(mk(8'h04, 0, 8'h00, 0, 3'd0, 8'h04, 8'h04, 1, 8'h00));
        vq.push_back(mk(8'h04, 0, 8'h00, 1, 3'd2, 8'h00, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00));
        // Masking the only request while ARMED drops back to IDLE
        vq.push_back(mk(8'h01, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h01, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h01, 0, 8'h00, 0, 3'd0, 8'h01, 8'h01, 0, 8'h00));
        vq.push_back(mk(8'h01, 0, 8'h00, 0, 3'd0, 8'h01, 8'h01, 1, 8'h00));
        vq.push_back(mk(8'h01, 1, 8'hFE, 0, 3'd0, 8'h01, 8'h00, 1, 8'h00));
        vq.push_back(mk(8'h01, 0, 8'h00, 0, 3'd0, 8'h01, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h01, 1, 8'hFF, 0, 3'd0, 8'h01, 8'h01, 0, 8'h00));
        vq.push_back(mk(8'h01, 0, 8'h00, 0, 3'd0, 8'h01, 8'h01, 1, 8'h00));
        vq.push_back(mk(8'h01, 0, 8'h00, 1, 3'd0, 8'h00, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00));
        vq.push_back(mk(8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00));

        for (int i = 0; i < vq.size(); i++) begin
            step($sformatf("vec%0d", i), vq[i].irq, vq[i].mwr, vq[i].mdin,
                 vq[i].av, vq[i].aidx, vq[i].epend, vq[i].ereq, vq[i].een, vq[i].eovf);
        end

        // T5 collision: ack 3 on the cycle bit 3 re-rises keeps it pending
        step("t5_a0", 8'h08, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
        step("t5_a1", 8'h08, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
        step("t5_a2", 8'h08, 0, 8'h00, 0, 3'd0, 8'h08, 8'h08, 0, 8'h00);
        step("t5_a3", 8'h08, 0, 8'h00, 0, 3'd0, 8'h08, 8'h08, 1, 8'h00);
        step("t5_a4", 8'h00, 0, 8'h00, 0, 3'd0, 8'h08, 8'h08, 1, 8'h00);
        step("t5_a5", 8'h00, 0, 8'h00, 0, 3'd0, 8'h08, 8'h08, 1, 8'h00);
        step("t5_a6", 8'h00, 0, 8'h00, 0, 3'd0, 8'h08, 8'h08, 1, 8'h00);
        step("t5_a7", 8'h08, 0, 8'h00, 0, 3'd0, 8'h08, 8'h08, 1, 8'h00);
        step("t5_a8", 8'h08, 0, 8'h00, 0, 3'd0, 8'h08, 8'h08, 1, 8'h00);
        step("t5_col", 8'h08, 0, 8'h00, 1, 3'd3, 8'h08, 8'h08, 0, 8'h00);
        // ack while in GAP is ignored; GAP re-arms since bit 3 is pending
        step("t5_gapack", 8'h08, 0, 8'h00, 1, 3'd3, 8'h08, 8'h08, 1, 8'h00);
        step("t5_armed", 8'h08, 0, 8'h00, 0, 3'd0, 8'h08, 8'h08, 1, 8'h00);

        // Asynchronous reset mid-ARMED, between clock edges
        #2 rst = 1'b1;
        #1;
        chk_all("t5_rst", 8'h00, 8'h00, 1'b0, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;

        // bit 3 held high through reset is captured once after release
        step("t5_b0", 8'h08, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
        step("t5_b1", 8'h08, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
        step("t5_b2", 8'h08, 0, 8'h00, 0, 3'd0, 8'h08, 8'h08, 0, 8'h00);
        step("t5_b3", 8'h08, 0, 8'h00, 0, 3'd0, 8'h08, 8'h08, 1, 8'h00);
        step("t5_b4", 8'h08, 0, 8'h00, 1, 3'd3, 8'h00, 8'h00, 0, 8'h00);
        step("t5_b5", 8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
        step("t5_b6", 8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
        step("t5_b7", 8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00);

        // T6 second edge on bit 4 before ack
        step("t6_c0", 8'h10, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
        step("t6_c1", 8'h10, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00);
        step("t6_c2", 8'h10, 0, 8'h00, 0, 3'd0, 8'h10, 8'h10, 0, 8'h00);
        step("t6_c3", 8'h00, 0, 8'h00, 0, 3'd0, 8'h10, 8'h10, 1, 8'h00);
        step("t6_c4", 8'h00, 0, 8'h00, 0, 3'd0, 8'h10, 8'h10, 1, 8'h00);
        step("t6_c5", 8'h00, 0, 8'h00, 0, 3'd0, 8'h10, 8'h10, 1, 8'h00);
        step("t6_c6", 8'h10, 0, 8'h00, 0, 3'd0, 8'h10, 8'h10, 1, 8'h00);
        step("t6_c7", 8'h10, 0, 8'h00, 0, 3'd0, 8'h10, 8'h10, 1, 8'h00);
        step("t6_ovf", 8'h10, 0, 8'h00, 0, 3'd0, 8'h10, 8'h10, 1, c_ovf4);
        step("t6_hold", 8'h10, 0, 8'h00, 0, 3'd0, 8'h10, 8'h10, 1, c_ovf4);
        step("t6_ack", 8'h10, 0, 8'h00, 1, 3'd4, 8'h00, 8'h00, 0, 8'h00);
        step("t6_idle", 8'h00, 0, 8'h00, 0, 3'd0, 8'h00, 8'h00, 0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
